// File: rtl/ucode_sequencer.sv
// Run-time programmable microcode sequencer: microword store, opcode/funct dispatch tables,
// bounded call stack. Define UCODE_COND_BRANCH_EN to make func 4 a conditional branch on cond_i.
module ucode_sequencer #(
  parameter  int CTRL_W      = 32,
  parameter  int DEPTH       = 256,
  parameter  int STACK_DEPTH = 8,
  localparam int AW          = $clog2(DEPTH),
  localparam int WORD_W      = 4 + AW + 1 + CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic              cond_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              eos_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [1:0]        err_o,
  input  logic              prog_we_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [WORD_W-1:0] prog_data_i,
  input  logic              tab_we_i,
  input  logic              tab_sel_i,
  input  logic [5:0]        tab_idx_i,
  input  logic [AW-1:0]     tab_addr_i
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       upc_q, upc_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [5:0]          funct_q, funct_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                eos_q, eos_d;
  logic [1:0]          err_q, err_d;

  logic [WORD_W-1:0]   mem_q   [DEPTH];
  logic [AW-1:0]       optab_q [64];
  logic [AW-1:0]       fntab_q [64];
  logic [63:0]         opvld_q, fnvld_q;
  logic [AW-1:0]       stack_q [STACK_DEPTH];

  logic [WORD_W-1:0]   wrd;
  logic [3:0]          w_func;
  logic [AW-1:0]       w_target;
  logic                w_eos;
  logic [CTRL_W-1:0]   w_ctrl;
  logic [AW-1:0]       upc_inc;
  logic [SPW-1:0]      sp_m1;
  logic                sp_full;
  logic                push, is_nop, seq;
  logic [1:0]          err_code;
  logic                prog_en, tab_en;

  assign wrd      = mem_q[upc_q];
  assign w_func   = wrd[WORD_W-1 -: 4];
  assign w_target = wrd[CTRL_W+1 +: AW];
  assign w_eos    = wrd[CTRL_W];
  assign w_ctrl   = wrd[CTRL_W-1:0];
  assign upc_inc  = upc_q + 1'b1;
  assign sp_m1    = sp_q - 1'b1;
  assign sp_full  = (sp_q == SPW'(STACK_DEPTH));
  assign prog_en  = prog_we_i && (state_q != S_RUN);
  assign tab_en   = tab_we_i && (state_q != S_RUN);

`ifndef UCODE_COND_BRANCH_EN
  logic unused_cond;
  assign unused_cond = cond_i;
`endif

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    sp_d     = sp_q;
    funct_d  = funct_q;
    ctrl_d   = '0;
    eos_d    = 1'b0;
    err_d    = err_q;
    push     = 1'b0;
    is_nop   = 1'b0;
    seq      = 1'b0;
    err_code = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (opcode_i == 6'h3F) begin
            state_d = S_HALT;
          end else if (!opvld_q[opcode_i]) begin
            err_code = 2'b10;
          end else begin
            upc_d   = optab_q[opcode_i];
            funct_d = funct_i;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        ctrl_d = w_ctrl;
        case (w_func)
          4'd1, 4'd2: begin
            if (sp_full) begin
              err_code = 2'b01;
            end else if (w_func == 4'd1) begin
              if (!opvld_q[w_target[5:0]]) err_code = 2'b10;
              else begin
                push  = 1'b1;
                upc_d = optab_q[w_target[5:0]];
              end
            end else begin
              if (!fnvld_q[funct_q]) err_code = 2'b10;
              else begin
                push  = 1'b1;
                upc_d = fntab_q[funct_q];
              end
            end
          end
          4'd3: upc_d = w_target;
`ifdef UCODE_COND_BRANCH_EN
          4'd4: begin
            if (cond_i) upc_d = w_target;
            else        seq   = 1'b1;
          end
`endif
          default: is_nop = 1'b1;
        endcase
        if (is_nop) begin
          if (!w_eos) begin
            seq = 1'b1;
          end else if (sp_q != '0) begin
            upc_d = stack_q[sp_m1[SIW-1:0]];
            sp_d  = sp_m1;
          end else begin
            eos_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (seq) begin
          // No wrap: stepping past the last word is a fault, not a loop.
          if (upc_q == AW'(DEPTH - 1)) err_code = 2'b11;
          else                         upc_d    = upc_inc;
        end
        if (push) sp_d = sp_q + 1'b1;
      end
      default: ;
    endcase
    if (err_code != 2'b00) begin
      state_d = S_ERR;
      err_d   = err_code;
      ctrl_d  = '0;
      eos_d   = 1'b0;
      upc_d   = upc_q;
      sp_d    = sp_q;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      sp_q    <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
      eos_q   <= 1'b0;
      err_q   <= 2'b00;
      opvld_q <= '0;
      fnvld_q <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_d;
      eos_q   <= eos_d;
      err_q   <= err_d;
      if (tab_en && !tab_sel_i) opvld_q[tab_idx_i] <= 1'b1;
      if (tab_en &&  tab_sel_i) fnvld_q[tab_idx_i] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (prog_en) mem_q[prog_addr_i] <= prog_data_i;
    if (tab_en && !tab_sel_i) optab_q[tab_idx_i] <= tab_addr_i;
    if (tab_en &&  tab_sel_i) fntab_q[tab_idx_i] <= tab_addr_i;
    if (push) stack_q[sp_q[SIW-1:0]] <= upc_inc;
  end

  assign ctrl_o   = ctrl_q;
  assign eos_o    = eos_q;
  assign busy_o   = (state_q == S_RUN);
  assign halted_o = (state_q == S_HALT);
  assign err_o    = err_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: call chain, dispatch, branch, reset, halt and error causes.
module tb_ucode_sequencer;
  localparam int CTRL_W = 32;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  localparam int WORD_W = 4 + AW + 1 + CTRL_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [5:0]        opcode_i = '0;
  logic [5:0]        funct_i = '0;
  logic              cond_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_o;
  logic              eos_o, busy_o, halted_o;
  logic [1:0]        err_o;
  logic              prog_we_i = 1'b0;
  logic [AW-1:0]     prog_addr_i = '0;
  logic [WORD_W-1:0] prog_data_i = '0;
  logic              tab_we_i = 1'b0;
  logic              tab_sel_i = 1'b0;
  logic [5:0]        tab_idx_i = '0;
  logic [AW-1:0]     tab_addr_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  ucode_sequencer #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .STACK_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
    .funct_i(funct_i), .cond_i(cond_i), .ctrl_o(ctrl_o), .eos_o(eos_o),
    .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .tab_we_i(tab_we_i), .tab_sel_i(tab_sel_i), .tab_idx_i(tab_idx_i),
    .tab_addr_i(tab_addr_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WORD_W-1:0] mkw(input logic [3:0] f, input logic [AW-1:0] t,
                                            input logic e, input logic [CTRL_W-1:0] c);
    return {f, t, e, c};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input int a, input logic [WORD_W-1:0] d);
    prog_we_i = 1'b1; prog_addr_i = AW'(a); prog_data_i = d;
    step();
    prog_we_i = 1'b0;
  endtask

  task automatic wr_tab(input logic sel, input int idx, input int a);
    tab_we_i = 1'b1; tab_sel_i = sel; tab_idx_i = 6'(idx); tab_addr_i = AW'(a);
    step();
    tab_we_i = 1'b0;
  endtask

  task automatic program_all();
    wr_word(0,  mkw(4'd1, 8'd2,   1'b0, 32'h100));
    wr_word(1,  mkw(4'd0, 8'd0,   1'b1, 32'h101));
    wr_word(2,  mkw(4'd1, 8'd3,   1'b0, 32'h102));
    wr_word(3,  mkw(4'd0, 8'd0,   1'b1, 32'h103));
    wr_word(4,  mkw(4'd1, 8'd1,   1'b0, 32'h104));
    wr_word(5,  mkw(4'd0, 8'd0,   1'b1, 32'h105));
    wr_word(6,  mkw(4'd0, 8'd0,   1'b1, 32'h106));
    wr_word(10, mkw(4'd0, 8'd0,   1'b1, 32'h04A));
    wr_word(12, mkw(4'd2, 8'd0,   1'b1, 32'h10C));
    wr_word(13, mkw(4'd0, 8'd0,   1'b1, 32'h10D));
    wr_word(14, mkw(4'd3, 8'd255, 1'b0, 32'h10E));
    wr_word(255, mkw(4'd0, 8'd0,  1'b0, 32'h1FF));
    wr_word(20, mkw(4'd0, 8'd0,   1'b1, 32'h114));
    wr_word(30, mkw(4'd4, 8'd20,  1'b0, 32'h11E));
    wr_word(31, mkw(4'd0, 8'd0,   1'b1, 32'h11F));
    for (int i = 40; i < 46; i++) wr_word(i, mkw(4'd0, 8'd0, (i == 45), 32'(256 + i)));
    wr_word(50, mkw(4'd1, 8'd10,  1'b0, 32'h132));
    wr_tab(1'b0, 0, 0);  wr_tab(1'b0, 1, 6);  wr_tab(1'b0, 2, 2);
    wr_tab(1'b0, 3, 4);  wr_tab(1'b0, 5, 12); wr_tab(1'b0, 6, 14);
    wr_tab(1'b0, 7, 30); wr_tab(1'b0, 8, 40); wr_tab(1'b0, 10, 50);
    wr_tab(1'b1, 6'h20, 10);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic start_seg(input logic [5:0] op, input logic [5:0] fn);
    start_i = 1'b1; opcode_i = op; funct_i = fn;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    int seq_exp [7];
    seq_exp = '{0, 2, 4, 6, 5, 3, 1};

    step();
    step();
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_eos", eos_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    program_all();

    // Call chain; a microword write while busy must be ignored.
    start_seg(6'd0, 6'd0);
    chk("cc_busy_start", busy_o, 1);
    chk("cc_ctrl_start", ctrl_o, 0);
    prog_we_i = 1'b1; prog_addr_i = 8'd1; prog_data_i = mkw(4'd0, 8'd0, 1'b1, 32'h999);
    for (int i = 0; i < 7; i++) begin
      step();
      prog_we_i = 1'b0;
      chk($sformatf("cc_ctrl_%0d", i), ctrl_o, 64'(256 + seq_exp[i]));
      chk($sformatf("cc_eos_%0d", i), eos_o, (i == 6));
      chk($sformatf("cc_busy_%0d", i), busy_o, (i != 6));
    end
    // Back-to-back start during the eos cycle.
    start_i = 1'b1; opcode_i = 6'd1;
    step();
    start_i = 1'b0;
    chk("b2b_ctrl0", ctrl_o, 0);
    chk("b2b_busy", busy_o, 1);
    step();
    chk("b2b_ctrl", ctrl_o, 32'h106);
    chk("b2b_eos", eos_o, 1);
    step();
    chk("b2b_idle_ctrl", ctrl_o, 0);
    chk("b2b_idle_busy", busy_o, 0);

    // Dispatch; a halt start while busy must be ignored.
    start_seg(6'd5, 6'h20);
    step();
    chk("dsp_ctrl0", ctrl_o, 32'h10C);
    chk("dsp_eos0", eos_o, 0);
    start_i = 1'b1; opcode_i = 6'h3F;
    step();
    start_i = 1'b0;
    chk("dsp_ctrl1", ctrl_o, 32'h04A);
    chk("dsp_eos1", eos_o, 0);
    step();
    chk("dsp_ctrl2", ctrl_o, 32'h10D);
    chk("dsp_eos2", eos_o, 1);
    step();
    chk("dsp_halted", halted_o, 0);
    chk("dsp_ctrl_idle", ctrl_o, 0);

    // Branch with cond high then low.
    cond_i = 1'b1;
    start_seg(6'd7, 6'd0);
    step();
    chk("br1_ctrl0", ctrl_o, 32'h11E);
    step();
`ifdef UCODE_COND_BRANCH_EN
    chk("br1_ctrl1", ctrl_o, 32'h114);
`else
    chk("br1_ctrl1", ctrl_o, 32'h11F);
`endif
    chk("br1_eos", eos_o, 1);
    step();
    cond_i = 1'b0;
    start_seg(6'd7, 6'd0);
    step();
    chk("br0_ctrl0", ctrl_o, 32'h11E);
    step();
    chk("br0_ctrl1", ctrl_o, 32'h11F);
    chk("br0_eos", eos_o, 1);
    step();

    // Reset three words into a six-word segment.
    start_seg(6'd8, 6'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr_ctrl_%0d", i), ctrl_o, 64'(296 + i));
    end
    rst_i = 1'b1;
    #1;
    chk("mr_ctrl", ctrl_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_eos", eos_o, 0);
    rst_i = 1'b0;
    start_seg(6'd8, 6'd0);
    chk("mr_tab_invalid_err", err_o, 2'b10);
    chk("mr_tab_invalid_busy", busy_o, 0);
    do_reset();
    program_all();
    start_seg(6'd8, 6'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rp_ctrl_%0d", i), ctrl_o, 64'(296 + i));
      chk($sformatf("rp_eos_%0d", i), eos_o, (i == 5));
    end
    step();

    // Reset with three return addresses stacked; stack must come back empty.
    start_seg(6'd0, 6'd0);
    step(); step(); step();
    do_reset();
    program_all();
    start_seg(6'd1, 6'd0);
    step();
    chk("stk_empty_ctrl", ctrl_o, 32'h106);
    chk("stk_empty_eos", eos_o, 1);
    step();

    // Halt is sticky.
    do_reset();
    start_seg(6'h3F, 6'd0);
    chk("halt_halted", halted_o, 1);
    chk("halt_ctrl", ctrl_o, 0);
    program_all();
    start_seg(6'd0, 6'd0);
    step();
    chk("halt_sticky", halted_o, 1);
    chk("halt_busy", busy_o, 0);
    chk("halt_err", err_o, 0);

    // Stack overflow from self-recursive CALL.
    do_reset();
    program_all();
    start_seg(6'd10, 6'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("ovf_ctrl_%0d", i), ctrl_o, 32'h132);
      chk($sformatf("ovf_err_%0d", i), err_o, 0);
    end
    step();
    chk("ovf_err", err_o, 2'b01);
    chk("ovf_ctrl", ctrl_o, 0);
    chk("ovf_busy", busy_o, 0);
    start_seg(6'd0, 6'd0);
    step();
    chk("ovf_sticky_err", err_o, 2'b01);
    chk("ovf_sticky_busy", busy_o, 0);
    chk("ovf_sticky_ctrl", ctrl_o, 0);

    // uPC overrun after JMP to the last word.
    do_reset();
    program_all();
    start_seg(6'd6, 6'd0);
    step();
    chk("ovr_ctrl_jmp", ctrl_o, 32'h10E);
    chk("ovr_err_pre", err_o, 0);
    step();
    chk("ovr_err", err_o, 2'b11);
    chk("ovr_ctrl", ctrl_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
